fifo_frame_sched: RTL and testbench

- Sequencer between the eight per-lane Intan sample FIFOs (two 8-bit lanes per Intan device) and the single downstream data FIFO.
- On an fs_fifo request it drains BURST bytes from every enabled lane in fixed order, lane 7 down to lane 0.
- It frames the bytes as: HEAD byte, payload, XOR checksum byte.
- It raises fd_fifo when the frame is complete.

---
 rtl/fifo_frame_sched.sv | 174 +++++++++++++++++
 tb/tb_fifo_frame_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_sched.sv
// Frame sequencer: drains BURST bytes from each enabled Intan lane FIFO (lane 7 down to 0)
// into the downstream data FIFO as HEAD, payload, XOR checksum.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | wait for fs_fifo
// HEAD   | write header byte
// SEL    | find next enabled lane, one lane per cycle
// RD     | wait for lane data and downstream room, or time out
// LAT    | lane FIFO read latency, capture byte
// PUSH   | write captured or pad byte
// TAIL   | write checksum
// DONE   | hold fd_fifo until fs_fifo drops
module fifo_frame_sched #(
  parameter logic [7:0] HEAD    = 8'hAA,
  parameter int         BURST   = 4,
  parameter int         TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_fifo,
  output logic        fd_fifo,
  output logic        err,
  input  logic [7:0]  dev_kind,
  input  logic [7:0]  fifoi_empty,
  output logic [7:0]  fifoi_rxen,
  input  logic [63:0] fifoi_rxd,
  input  logic        fifod_full,
  output logic        fifod_txen,
  output logic [7:0]  fifod_txd
);

  localparam logic [7:0] BURST_B   = 8'(BURST);
  localparam logic [7:0] TIMEOUT_B = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_SEL, S_RD, S_LAT, S_PUSH, S_TAIL, S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [7:0]  lane_en;
  logic [7:0]  bcnt;
  logic [7:0]  tcnt;
  logic [7:0]  data_q;
  logic [7:0]  csum;
  logic        err_q;

  logic        lane_empty;
  logic [7:0]  lane_rxd;
  logic        read_go;
  logic        wr_go;

  function automatic logic [7:0] lane_enable(input logic [7:0] kind);
    logic [7:0] en;
    logic [1:0] f;
    en = 8'h00;
    for (int k = 0; k < 4; k++) begin
      f = kind[2*k +: 2];
      en[2*k+1] = (f != 2'b00);
      en[2*k]   = f[1];
    end
    return en;
  endfunction

  assign lane_empty = fifoi_empty[ptr];
  assign lane_rxd   = fifoi_rxd[{ptr, 3'b000} +: 8];

  // Strobes are gated by the same-cycle full/empty flags so a write never
  // lands on a full FIFO and a byte is never read without room to push it.
  assign read_go    = (state == S_RD) && !lane_empty && !fifod_full;
  assign wr_go      = ((state == S_HEAD) || (state == S_PUSH) || (state == S_TAIL)) && !fifod_full;

  assign fifoi_rxen = read_go ? (8'h01 << ptr) : 8'h00;
  assign fifod_txen = wr_go;
  assign fd_fifo    = (state == S_DONE);
  assign err        = err_q;

  always_comb begin
    fifod_txd = 8'h00;
    if (wr_go) begin
      case (state)
        S_HEAD:  fifod_txd = HEAD;
        S_PUSH:  fifod_txd = data_q;
        S_TAIL:  fifod_txd = csum;
        default: fifod_txd = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ptr     <= 3'd0;
      lane_en <= 8'h00;
      bcnt    <= 8'h00;
      tcnt    <= 8'h00;
      data_q  <= 8'h00;
      csum    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fs_fifo) begin
            lane_en <= lane_enable(dev_kind);
            err_q   <= 1'b0;
            csum    <= 8'h00;
            ptr     <= 3'd7;
            state   <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (!fifod_full) begin
            csum  <= csum ^ HEAD;
            state <= S_SEL;
          end
        end
        S_SEL: begin
          if (lane_en[ptr]) begin
            bcnt  <= BURST_B;
            tcnt  <= 8'h00;
            state <= S_RD;
          end else if (ptr == 3'd0) begin
            state <= S_TAIL;
          end else begin
            ptr <= ptr - 3'd1;
          end
        end
        S_RD: begin
          if (read_go) begin
            state <= S_LAT;
          end else if (lane_empty) begin
            if (tcnt + 8'd1 == TIMEOUT_B) begin
              err_q  <= 1'b1;
              data_q <= 8'h00;
              state  <= S_PUSH;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
        end
        S_LAT: begin
          data_q <= lane_rxd;
          state  <= S_PUSH;
        end
        S_PUSH: begin
          if (!fifod_full) begin
            csum <= csum ^ data_q;
            bcnt <= bcnt - 8'd1;
            if (bcnt == 8'd1) begin
              if (ptr == 3'd0) begin
                state <= S_TAIL;
              end else begin
                ptr   <= ptr - 3'd1;
                state <= S_SEL;
              end
            end else begin
              tcnt  <= 8'h00;
              state <= S_RD;
            end
          end
        end
        S_TAIL: begin
          if (!fifod_full) state <= S_DONE;
        end
        S_DONE: begin
          if (!fs_fifo) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_sched.sv
// Bench for fifo_frame_sched: lane FIFO models, expected-byte scoreboard queue,
// table of frame configurations plus hand-written reset and timing sequences.
module tb_fifo_frame_sched;

  localparam logic [7:0] HEAD    = 8'hAA;
  localparam int         BURST   = 4;
  localparam int         TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs_fifo = 1'b0;
  logic        fd_fifo;
  logic        err;
  logic [7:0]  dev_kind = 8'h00;
  logic [7:0]  fifoi_empty = 8'h00;
  logic [7:0]  fifoi_rxen;
  logic [63:0] fifoi_rxd;
  logic        fifod_full = 1'b0;
  logic        fifod_txen;
  logic [7:0]  fifod_txd;

  always #5 clk = ~clk;

  fifo_frame_sched #(.HEAD(HEAD), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fs_fifo(fs_fifo), .fd_fifo(fd_fifo), .err(err),
    .dev_kind(dev_kind), .fifoi_empty(fifoi_empty), .fifoi_rxen(fifoi_rxen),
    .fifoi_rxd(fifoi_rxd), .fifod_full(fifod_full), .fifod_txen(fifod_txen),
    .fifod_txd(fifod_txd)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int wcount = 0;
  int rx_lane[8] = '{default: 0};
  int pop_cnt[8] = '{default: 0};
  logic [7:0] lane_d[8] = '{default: 8'hEE};
  logic [7:0] rx_pend = 8'h00;
  bit tog_en = 1'b0;
  logic [7:0] exp_q[$];
  int w_cyc[$];

  typedef struct {
    string      name;
    logic [7:0] dk;
    logic [7:0] empty;
    bit         tog;
    int         len;
    bit         err;
    int         gap;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
  endtask

  // Lane n yields (n+1)*16 + k on its k-th pop; data appears the cycle after rxen.
  function automatic logic [7:0] lane_val(input int n, input int k);
    return 8'((n + 1) * 16 + k);
  endfunction

  always_comb begin
    fifoi_rxd = '0;
    for (int n = 0; n < 8; n++) fifoi_rxd[8*n +: 8] = lane_d[n];
  end

  always @(posedge clk) begin
    for (int n = 0; n < 8; n++) begin
      if (rx_pend[n]) begin
        lane_d[n]  <= lane_val(n, pop_cnt[n]);
        pop_cnt[n] <= pop_cnt[n] + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    fifod_full = tog_en ? ~fifod_full : 1'b0;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    rx_pend = fifoi_rxen & ~fifoi_empty;
    if (fifoi_rxen != 8'h00) begin
      check($onehot(fifoi_rxen) && ((fifoi_rxen & fifoi_empty) == 8'h00), "rxen_legal",
            32'(fifoi_rxen), 32'(fifoi_empty));
      for (int n = 0; n < 8; n++) if (fifoi_rxen[n]) rx_lane[n]++;
    end
    if (fifod_txen) begin
      check(!fifod_full, "txen_while_full", 32'(fifod_full), 32'd0);
      if (exp_q.size() == 0) begin
        check(1'b0, "extra_write", 32'(fifod_txd), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check(fifod_txd == e, "txd", 32'(fifod_txd), 32'(e));
      end
      w_cyc.push_back(cyc);
      wcount++;
    end
  end

  task automatic build_exp(input logic [7:0] dk, input logic [7:0] emp, output logic [7:0] en);
    logic [7:0] cs;
    logic [7:0] v;
    logic [1:0] f;
    exp_q.delete();
    en = 8'h00;
    for (int k = 0; k < 4; k++) begin
      f = dk[2*k +: 2];
      en[2*k+1] = (f != 2'b00);
      en[2*k]   = f[1];
    end
    cs = HEAD;
    exp_q.push_back(HEAD);
    for (int n = 7; n >= 0; n--) begin
      if (en[n]) begin
        for (int b = 0; b < BURST; b++) begin
          v = emp[n] ? 8'h00 : lane_val(n, pop_cnt[n] + b);
          exp_q.push_back(v);
          cs = cs ^ v;
        end
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic run_frame(input vec_t v);
    int w0;
    int rx0[8];
    int exp_rx;
    bit done;
    logic [7:0] en;
    build_exp(v.dk, v.empty, en);
    w0  = wcount;
    rx0 = rx_lane;
    @(posedge clk); #1;
    dev_kind    = v.dk;
    fifoi_empty = v.empty;
    fs_fifo     = 1'b1;
    tog_en      = v.tog;
    @(posedge clk);
    @(negedge clk);
    check(err == 1'b0, {v.name, "_err_clear"}, 32'(err), 32'd0);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (fd_fifo) done = 1'b1;
    end
    check(done, {v.name, "_fd_timeout"}, 32'(done), 32'd1);
    tog_en = 1'b0;
    check(wcount - w0 == v.len, {v.name, "_frame_len"}, 32'(wcount - w0), 32'(v.len));
    check(exp_q.size() == 0, {v.name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check(err == v.err, {v.name, "_err_done"}, 32'(err), 32'(v.err));
    for (int n = 0; n < 8; n++) begin
      exp_rx = (en[n] && !v.empty[n]) ? BURST : 0;
      check(rx_lane[n] - rx0[n] == exp_rx, $sformatf("%s_rxen_lane%0d", v.name, n),
            32'(rx_lane[n] - rx0[n]), 32'(exp_rx));
    end
    if (v.gap != 0) begin
      if (w_cyc.size() > w0 + 2)
        check(w_cyc[w0+2] - w_cyc[w0+1] == v.gap, {v.name, "_payload_gap"},
              32'(w_cyc[w0+2] - w_cyc[w0+1]), 32'(v.gap));
      else
        check(1'b0, {v.name, "_payload_gap_missing"}, 32'(w_cyc.size()), 32'(w0 + 3));
    end
    @(posedge clk); #1;
    fs_fifo = 1'b0;
    @(negedge clk);
    check(fd_fifo == 1'b1, {v.name, "_fd_hold"}, 32'(fd_fifo), 32'd1);
    @(negedge clk);
    check(fd_fifo == 1'b0, {v.name, "_fd_drop"}, 32'(fd_fifo), 32'd0);
    check(err == v.err, {v.name, "_err_hold"}, 32'(err), 32'(v.err));
  endtask

  task automatic check_quiet(input string tag);
    check(fd_fifo == 1'b0,       {tag, "_fd"},   32'(fd_fifo),    32'd0);
    check(err == 1'b0,           {tag, "_err"},  32'(err),        32'd0);
    check(fifoi_rxen == 8'h00,   {tag, "_rxen"}, 32'(fifoi_rxen), 32'd0);
    check(fifod_txen == 1'b0,    {tag, "_txen"}, 32'(fifod_txen), 32'd0);
    check(fifod_txd == 8'h00,    {tag, "_txd"},  32'(fifod_txd),  32'd0);
  endtask

  initial begin
    logic [7:0] en;
    int  w0;
    int  w1;
    bit  hit;

    vecs[0] = '{"all_lanes",    8'hFF, 8'h00, 1'b0, 34, 1'b0, 3};
    vecs[1] = '{"lanes_7_3_2",  8'h48, 8'h00, 1'b0, 14, 1'b0, 3};
    vecs[2] = '{"no_lanes",     8'h00, 8'h00, 1'b0,  2, 1'b0, 0};
    vecs[3] = '{"timeout_l7",   8'h40, 8'h80, 1'b0,  6, 1'b1, TIMEOUT + 1};
    vecs[4] = '{"full_toggle",  8'hFF, 8'h00, 1'b1, 34, 1'b0, 0};
    vecs[5] = '{"mixed_pad_l1", 8'hA5, 8'h02, 1'b0, 26, 1'b1, 3};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Reset asserted while the sequencer is pushing payload.
    build_exp(8'hFF, 8'h00, en);
    w0 = wcount;
    @(posedge clk); #1;
    dev_kind    = 8'hFF;
    fifoi_empty = 8'h00;
    fs_fifo     = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (fifod_txen && (wcount - w0 >= 4)) hit = 1'b1;
    end
    check(hit, "reach_push", 32'(hit), 32'd1);
    rst     = 1'b0;
    fs_fifo = 1'b0;
    @(negedge clk);
    check_quiet("mid_rst");
    exp_q.delete();
    w1 = wcount;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check(wcount == w1, "no_write_after_rst", 32'(wcount - w1), 32'd0);
    check(fd_fifo == 1'b0, "idle_after_rst_fd", 32'(fd_fifo), 32'd0);
    vecs[0].name = "post_rst";
    run_frame(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
